disp_scan_ctrl: RTL

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

---
 rtl/disp_pkg.sv | 36 +++
 rtl/disp_prescaler.sv | 40 ++++
 rtl/disp_scan_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared constants, parameter defaults and the frame record for the display
// scan controller.
package disp_pkg;

   localparam int NUM_DIGITS    = 8;
   localparam int SCAN_W        = 3;
   localparam int HEX_W         = 32;

   localparam int DIV_W_DEF     = 16;
   localparam int BLANK_CYC_DEF = 4;
   localparam int BLINK_W_DEF   = 24;

   localparam logic [SCAN_W-1:0] LAST_DIGIT = SCAN_W'(NUM_DIGITS - 1);

   // One complete frame as seen by the downstream scan mux.
   typedef struct packed {
      logic [HEX_W-1:0]      hexs;
      logic [NUM_DIGITS-1:0] point;
      logic [NUM_DIGITS-1:0] les;
      logic [NUM_DIGITS-1:0] blink;
   } frame_t;

   // Points are active-low, so an idle frame has every point bit high.
   localparam frame_t FRAME_RST = '{
      hexs:  {HEX_W{1'b0}},
      point: {NUM_DIGITS{1'b1}},
      les:   {NUM_DIGITS{1'b0}},
      blink: {NUM_DIGITS{1'b0}}
   };

   function automatic logic [NUM_DIGITS-1:0] gate_les(input frame_t f,
                                                      input logic   blink_off);
      return f.les & ~(f.blink & {NUM_DIGITS{blink_off}});
   endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Digit-slot prescaler: counts enabled cycles and flags the last cycle of
// every slot.
module disp_prescaler
   import disp_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [DIV_W-1:0] div_cnt,
   output logic             tick
);

   logic [DIV_W-1:0] div_cnt_q;
   logic [DIV_W-1:0] div_cnt_d;

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      div_cnt_d = div_cnt_q;
      if (en) begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops
   // sample their inputs from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
      end
   end

   assign div_cnt = div_cnt_q;
   assign tick    = en && (div_cnt_q == {DIV_W{1'b1}});

endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit display scan controller: digit sequencing, slot blanking,
// tear-free double-buffered frame loading and per-digit blinking.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int DIV_W     = DIV_W_DEF,
   parameter int BLANK_CYC = BLANK_CYC_DEF,
   parameter int BLINK_W   = BLINK_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [HEX_W-1:0]      hexs_in,
   input  logic [NUM_DIGITS-1:0] point_in,
   input  logic [NUM_DIGITS-1:0] les_in,
   input  logic [NUM_DIGITS-1:0] blink_in,
   output logic [SCAN_W-1:0]     Scan,
   output logic [HEX_W-1:0]      Hexs,
   output logic [NUM_DIGITS-1:0] point,
   output logic [NUM_DIGITS-1:0] LES,
   output logic                  blank,
   output logic                  frame_done
);

   logic [DIV_W-1:0]   div_cnt;
   logic               tick;
   logic               wrap;
   logic               ld_fire;

   logic [SCAN_W-1:0]  scan_q,        scan_d;
   logic               frame_done_q,  frame_done_d;
   logic               shadow_full_q, shadow_full_d;
   frame_t             shadow_q,      shadow_d;
   frame_t             disp_q,        disp_d;
   logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;

   disp_prescaler #(
      .DIV_W (DIV_W)
   ) u_prescaler (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .div_cnt (div_cnt),
      .tick    (tick)
   );

   assign wrap    = tick && (scan_q == LAST_DIGIT);
   assign ld_fire = ld_valid && !shadow_full_q;

   always_comb begin
      scan_d        = scan_q;
      frame_done_d  = wrap;
      shadow_full_d = shadow_full_q;
      shadow_d      = shadow_q;
      disp_d        = disp_q;
      blink_cnt_d   = blink_cnt_q + BLINK_W'(1);

      if (tick) begin
         scan_d = scan_q + SCAN_W'(1);
      end

      // A load needs an empty shadow and a transfer needs a full one, so the
      // two can never coincide; data offered on a wrap waits a whole frame.
      if (wrap && shadow_full_q) begin
         disp_d        = shadow_q;
         shadow_full_d = 1'b0;
      end else if (ld_fire) begin
         shadow_d      = '{hexs: hexs_in, point: point_in,
                           les: les_in, blink: blink_in};
         shadow_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_q        <= '0;
         frame_done_q  <= 1'b0;
         shadow_full_q <= 1'b0;
         disp_q        <= FRAME_RST;
         blink_cnt_q   <= '0;
      end else begin
         scan_q        <= scan_d;
         frame_done_q  <= frame_done_d;
         shadow_full_q <= shadow_full_d;
         disp_q        <= disp_d;
         blink_cnt_q   <= blink_cnt_d;
      end
   end

   // NOTE: the shadow payload is left without reset on purpose; it is only
   // ever read while shadow_full_q is set, and that flag is reset.
   always_ff @(posedge clk) begin
      shadow_q <= shadow_d;
   end

   assign ld_ready   = !shadow_full_q;
   assign Scan       = scan_q;
   assign Hexs       = disp_q.hexs;
   assign point      = disp_q.point;
   assign LES        = gate_les(disp_q, blink_cnt_q[BLINK_W-1]);
   assign blank      = !en || (div_cnt < DIV_W'(BLANK_CYC));
   assign frame_done = frame_done_q;

endmodule
